credit_txn_ctrl: RTL

//   Transaction controller for the mess credit ledger. It holds one 8-bit credit balance per student.

---
 rtl/credit_pkg.sv | 29 ++
 rtl/adder_8bit_gate.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/credit_txn_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// Shared types for the credit ledger: op encoding, response codes, FSM states and the response record.
package credit_pkg;

    localparam int CREDIT_W = 8;

    localparam logic OP_RECHARGE = 1'b0;
    localparam logic OP_DEDUCT   = 1'b1;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_INSUFF = 2'b01,
        ERR_OVF    = 2'b10,
        ERR_BADID  = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    typedef struct packed {
        logic                ok;
        err_t                err;
        logic [CREDIT_W-1:0] bal;
    } rsp_t;

endpackage

// File: rtl/adder_8bit_gate.sv
// 8-bit ripple-carry adder built from explicit full-adder gate equations.
// Latency: combinational.
// Backpressure: none.
module adder_8bit_gate (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[8];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr (wrapping), as one-hot grant plus index.
// Latency: combinational.
// Backpressure: any = 0 when no request is present.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/credit_txn_ctrl.sv
// Round-robin front-end running recharge/deduct on a per-student 8-bit ledger through one shared adder.
// Latency: grant in IDLE, rsp_valid 3 cycles later, one transaction per 4 cycles; CREDIT_SATURATE_EN clamps recharge overflow to 255.
// Backpressure: requesters hold until their req_ready pulse; rsp has none.
module credit_txn_ctrl
    import credit_pkg::*;
#(
    parameter int                  NUM_REQ      = 2,
    parameter int                  NUM_STUDENTS = 16,
    parameter logic [CREDIT_W-1:0] INIT_CREDIT  = 8'd100,
    localparam int                 ID_W         = $clog2(NUM_STUDENTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_op,
    input  logic [NUM_REQ*ID_W-1:0]      req_id,
    input  logic [NUM_REQ*CREDIT_W-1:0]  req_amt,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [2:0]                   rsp_src,
    output logic                         rsp_ok,
    output logic [1:0]                   rsp_err,
    output logic [CREDIT_W-1:0]          rsp_balance,
    output logic                         busy
);

    localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ID_SPACE = 2 ** ID_W;

    state_t               state, state_nxt;
    logic [SRC_W-1:0]     rr_ptr, gnt_idx, lat_src;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic                 gnt_any;
    logic                 lat_op;
    logic [ID_W-1:0]      lat_id;
    logic [CREDIT_W-1:0]  lat_amt;
    logic                 bad_id;
    logic [CREDIT_W-1:0]  opa;
    logic [CREDIT_W-1:0]  add_b, add_sum;
    logic                 add_cin, add_cout;
    logic [CREDIT_W-1:0]  ledger [NUM_STUDENTS];
    logic [ID_SPACE-1:0]  id_valid_map;
    logic [ID_W-1:0]      id_arr  [NUM_REQ];
    logic [CREDIT_W-1:0]  amt_arr [NUM_REQ];
    rsp_t                 exec_rsp;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign id_arr[g]  = req_id[g*ID_W +: ID_W];
        assign amt_arr[g] = req_amt[g*CREDIT_W +: CREDIT_W];
    end

    // Ids that encode past the ledger depth are rejected rather than aliased.
    always_comb begin
        for (int i = 0; i < ID_SPACE; i++) id_valid_map[i] = (i < NUM_STUDENTS);
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(SRC_W)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt_oh),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = (state == S_IDLE && !rst) ? gnt_oh : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gnt_any) state_nxt = S_READ;
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Deduct is a + ~amt + 1, so carry-out low means the balance was smaller than amt.
    assign add_b   = (lat_op == OP_DEDUCT) ? ~lat_amt : lat_amt;
    assign add_cin = (lat_op == OP_DEDUCT);

    adder_8bit_gate u_add (
        .a    (opa),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        exec_rsp.ok  = 1'b1;
        exec_rsp.err = ERR_NONE;
        exec_rsp.bal = add_sum;
        if (bad_id) begin
            exec_rsp.ok  = 1'b0;
            exec_rsp.err = ERR_BADID;
            exec_rsp.bal = opa;
        end else if (lat_op == OP_DEDUCT && !add_cout) begin
            exec_rsp.ok  = 1'b0;
            exec_rsp.err = ERR_INSUFF;
            exec_rsp.bal = opa;
        end else if (lat_op == OP_RECHARGE && add_cout) begin
            exec_rsp.err = ERR_OVF;
`ifdef CREDIT_SATURATE_EN
            exec_rsp.bal = '1;
`else
            exec_rsp.ok  = 1'b0;
            exec_rsp.bal = opa;
`endif
        end
    end

    // The response is registered at the end of EXEC so rsp_valid coincides with the WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            lat_src     <= '0;
            lat_op      <= 1'b0;
            lat_id      <= '0;
            lat_amt     <= '0;
            bad_id      <= 1'b0;
            opa         <= '0;
            rsp_valid   <= 1'b0;
            rsp_src     <= '0;
            rsp_ok      <= 1'b0;
            rsp_err     <= '0;
            rsp_balance <= '0;
            for (int i = 0; i < NUM_STUDENTS; i++) ledger[i] <= INIT_CREDIT;
        end else begin
            rsp_valid <= (state == S_EXEC);
            case (state)
                S_IDLE: if (gnt_any) begin
                    lat_src <= gnt_idx;
                    lat_op  <= req_op[gnt_idx];
                    lat_id  <= id_arr[gnt_idx];
                    lat_amt <= amt_arr[gnt_idx];
                    rr_ptr  <= (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
                end
                S_READ: begin
                    bad_id <= !id_valid_map[lat_id];
                    opa    <= id_valid_map[lat_id] ? ledger[lat_id] : '0;
                end
                S_EXEC: begin
                    rsp_src     <= 3'(lat_src);
                    rsp_ok      <= exec_rsp.ok;
                    rsp_err     <= exec_rsp.err;
                    rsp_balance <= exec_rsp.bal;
                end
                S_WRITE: if (rsp_ok) ledger[lat_id] <= rsp_balance;
                default: ;
            endcase
        end
    end

endmodule
